// File: rtl/core_pipe_dispatch.sv
// core_pipe_dispatch: decode-to-execute pipeline register with RAW stall, writeback forwarding and flush.
module core_pipe_dispatch #(
  parameter int XL         = 63,
  parameter int REG_ADDR_R = 4,
  parameter int ALU_OP_R   = 4,
  parameter int LSU_OP_R   = 4,
  parameter int MDU_OP_R   = 2,
  parameter int CSR_OP_R   = 3,
  parameter int CFU_OP_R   = 2
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic [XL:0]           s1_pc,
  input  logic [XL:0]           s1_opr_a,
  input  logic [XL:0]           s1_opr_b,
  input  logic [XL:0]           s1_opr_c,
  input  logic [REG_ADDR_R:0]   s1_rs1,
  input  logic [REG_ADDR_R:0]   s1_rs2,
  input  logic                  s1_rs1_used,
  input  logic                  s1_rs2_used,
  input  logic [REG_ADDR_R:0]   s1_rd,
  input  logic                  s1_rd_used,
  input  logic [ALU_OP_R:0]     s1_alu_op,
  input  logic [LSU_OP_R:0]     s1_lsu_op,
  input  logic [MDU_OP_R:0]     s1_mdu_op,
  input  logic [CSR_OP_R:0]     s1_csr_op,
  input  logic [CFU_OP_R:0]     s1_cfu_op,
  input  logic                  s1_op_w,
  input  logic [31:0]           s1_instr,
  output logic                  s2_valid,
  input  logic                  s2_ready,
  output logic [XL:0]           s2_pc,
  output logic [XL:0]           s2_opr_a,
  output logic [XL:0]           s2_opr_b,
  output logic [XL:0]           s2_opr_c,
  output logic [REG_ADDR_R:0]   s2_rd,
  output logic [ALU_OP_R:0]     s2_alu_op,
  output logic [LSU_OP_R:0]     s2_lsu_op,
  output logic [MDU_OP_R:0]     s2_mdu_op,
  output logic [CSR_OP_R:0]     s2_csr_op,
  output logic [CFU_OP_R:0]     s2_cfu_op,
  output logic                  s2_op_w,
  output logic [31:0]           s2_instr,
  input  logic                  s2_rd_wen,
  input  logic [REG_ADDR_R:0]   s2_rd_addr,
  input  logic [XL:0]           s2_rd_wdata,
  input  logic                  s2_cf_valid,
  input  logic                  s2_cf_ack
);
  logic                buf_valid_q, buf_valid_d;
  logic                rd_pend_q, rd_pend_d;
  logic [XL:0]         pc_q, opr_a_q, opr_b_q, opr_c_q;
  logic [REG_ADDR_R:0] rd_q;
  logic [ALU_OP_R:0]   alu_op_q;
  logic [LSU_OP_R:0]   lsu_op_q;
  logic [MDU_OP_R:0]   mdu_op_q;
  logic [CSR_OP_R:0]   csr_op_q;
  logic [CFU_OP_R:0]   cfu_op_q;
  logic                op_w_q;
  logic [31:0]         instr_q;
  logic cf_flush, hit_rs1, hit_rs2, hit_rd, hazard, slot_free, load;
  logic [XL:0] opr_a_d, opr_b_d;
  // Writes to x0 are never treated as hits, so x0 neither stalls nor forwards.
  always_comb begin
    cf_flush  = s2_cf_valid && s2_cf_ack;
    hit_rs1   = s2_rd_wen && s2_rd_addr == s1_rs1 && s1_rs1 != '0;
    hit_rs2   = s2_rd_wen && s2_rd_addr == s1_rs2 && s1_rs2 != '0;
    hit_rd    = s2_rd_wen && s2_rd_addr == rd_q && rd_q != '0;
    hazard    = buf_valid_q && rd_pend_q && rd_q != '0 &&
                ((s1_rs1_used && s1_rs1 == rd_q) || (s1_rs2_used && s1_rs2 == rd_q)) && !hit_rd;
    slot_free = !buf_valid_q || s2_ready;
    load      = s1_valid && slot_free && !hazard && !s2_cf_valid;
    opr_a_d   = (s1_rs1_used && hit_rs1) ? s2_rd_wdata : s1_opr_a;
    opr_b_d   = (s1_rs2_used && hit_rs2) ? s2_rd_wdata : s1_opr_b;
    buf_valid_d = cf_flush ? 1'b0 : load ? 1'b1 : (buf_valid_q && s2_ready) ? 1'b0 : buf_valid_q;
    rd_pend_d   = cf_flush ? 1'b0 : load ? (s1_rd_used && s1_rd != '0) :
                  (buf_valid_q && s2_ready) ? 1'b0 : hit_rd ? 1'b0 : rd_pend_q;
  end
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      buf_valid_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      pc_q        <= '0;
      opr_a_q     <= '0;
      opr_b_q     <= '0;
      opr_c_q     <= '0;
      rd_q        <= '0;
      alu_op_q    <= '0;
      lsu_op_q    <= '0;
      mdu_op_q    <= '0;
      csr_op_q    <= '0;
      cfu_op_q    <= '0;
      op_w_q      <= 1'b0;
      instr_q     <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      rd_pend_q   <= rd_pend_d;
      if (load) begin
        pc_q     <= s1_pc;
        opr_a_q  <= opr_a_d;
        opr_b_q  <= opr_b_d;
        opr_c_q  <= s1_opr_c;
        rd_q     <= s1_rd;
        alu_op_q <= s1_alu_op;
        lsu_op_q <= s1_lsu_op;
        mdu_op_q <= s1_mdu_op;
        csr_op_q <= s1_csr_op;
        cfu_op_q <= s1_cfu_op;
        op_w_q   <= s1_op_w;
        instr_q  <= s1_instr;
      end
    end
  end
  assign s1_ready  = load;
  assign s2_valid  = buf_valid_q;
  assign s2_pc     = pc_q;
  assign s2_opr_a  = opr_a_q;
  assign s2_opr_b  = opr_b_q;
  assign s2_opr_c  = opr_c_q;
  assign s2_rd     = rd_q;
  assign s2_alu_op = alu_op_q;
  assign s2_lsu_op = lsu_op_q;
  assign s2_mdu_op = mdu_op_q;
  assign s2_csr_op = csr_op_q;
  assign s2_cfu_op = cfu_op_q;
  assign s2_op_w   = op_w_q;
  assign s2_instr  = instr_q;
endmodule

// File: tb/tb_core_pipe_dispatch.sv
// tb_core_pipe_dispatch: directed vectors for the decode/execute pipeline register.
module tb_core_pipe_dispatch;
  logic        g_clk = 1'b0, g_resetn = 1'b0;
  logic        s1_valid, s1_ready, s1_rs1_used, s1_rs2_used, s1_rd_used, s1_op_w;
  logic [63:0] s1_pc, s1_opr_a, s1_opr_b, s1_opr_c;
  logic [4:0]  s1_rs1, s1_rs2, s1_rd;
  logic [4:0]  s1_alu_op, s1_lsu_op;
  logic [2:0]  s1_mdu_op, s2_mdu_op;
  logic [3:0]  s1_csr_op, s2_csr_op;
  logic [2:0]  s1_cfu_op, s2_cfu_op;
  logic [31:0] s1_instr, s2_instr;
  logic        s2_valid, s2_ready, s2_op_w, s2_rd_wen, s2_cf_valid, s2_cf_ack;
  logic [63:0] s2_pc, s2_opr_a, s2_opr_b, s2_opr_c, s2_rd_wdata;
  logic [4:0]  s2_rd, s2_rd_addr, s2_alu_op, s2_lsu_op;
  int errors = 0, checks = 0;

  core_pipe_dispatch dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .s1_pc(s1_pc), .s1_opr_a(s1_opr_a), .s1_opr_b(s1_opr_b), .s1_opr_c(s1_opr_c),
    .s1_rs1(s1_rs1), .s1_rs2(s1_rs2), .s1_rs1_used(s1_rs1_used), .s1_rs2_used(s1_rs2_used),
    .s1_rd(s1_rd), .s1_rd_used(s1_rd_used), .s1_alu_op(s1_alu_op), .s1_lsu_op(s1_lsu_op),
    .s1_mdu_op(s1_mdu_op), .s1_csr_op(s1_csr_op), .s1_cfu_op(s1_cfu_op), .s1_op_w(s1_op_w),
    .s1_instr(s1_instr), .s2_valid(s2_valid), .s2_ready(s2_ready), .s2_pc(s2_pc),
    .s2_opr_a(s2_opr_a), .s2_opr_b(s2_opr_b), .s2_opr_c(s2_opr_c), .s2_rd(s2_rd),
    .s2_alu_op(s2_alu_op), .s2_lsu_op(s2_lsu_op), .s2_mdu_op(s2_mdu_op), .s2_csr_op(s2_csr_op),
    .s2_cfu_op(s2_cfu_op), .s2_op_w(s2_op_w), .s2_instr(s2_instr), .s2_rd_wen(s2_rd_wen),
    .s2_rd_addr(s2_rd_addr), .s2_rd_wdata(s2_rd_wdata), .s2_cf_valid(s2_cf_valid),
    .s2_cf_ack(s2_cf_ack)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic instr(input logic [63:0] pc, input logic [4:0] rs1, input logic rs1_u,
                       input logic [4:0] rs2, input logic rs2_u, input logic [4:0] rd,
                       input logic rd_u, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] alu);
    s1_pc = pc; s1_rs1 = rs1; s1_rs1_used = rs1_u; s1_rs2 = rs2; s1_rs2_used = rs2_u;
    s1_rd = rd; s1_rd_used = rd_u; s1_opr_a = a; s1_opr_b = b; s1_opr_c = 64'hC0C0;
    s1_alu_op = alu; s1_instr = pc[31:0] ^ 32'h13;
  endtask

  initial begin
    s1_valid = 0; s1_op_w = 0; s1_lsu_op = 0; s1_mdu_op = 0; s1_csr_op = 0; s1_cfu_op = 0;
    instr(64'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s2_ready = 0; s2_rd_wen = 0; s2_rd_addr = 0; s2_rd_wdata = 0; s2_cf_valid = 0; s2_cf_ack = 0;
    #3;
    chk("reset_valid", s2_valid, 0);
    chk("reset_alu_op", s2_alu_op, 0);
    chk("reset_pc", s2_pc, 0);
    step();
    g_resetn = 1;
    // back-to-back
    s1_valid = 1; s2_ready = 1;
    instr(64'h100, 1, 1, 2, 1, 3, 1, 64'hA0, 64'hB0, 5'd1);
    #1 chk("b2b_ready", s1_ready, 1);
    step(); chk("b2b_pc0", s2_pc, 64'h100); chk("b2b_v0", s2_valid, 1); chk("b2b_alu0", s2_alu_op, 1);
    instr(64'h104, 1, 1, 2, 1, 4, 1, 64'hA1, 64'hB1, 5'd2);
    step(); chk("b2b_pc1", s2_pc, 64'h104); chk("b2b_v1", s2_valid, 1);
    instr(64'h108, 1, 1, 2, 1, 0, 0, 64'hA2, 64'hB2, 5'd3);
    step(); chk("b2b_pc2", s2_pc, 64'h108); chk("b2b_v2", s2_valid, 1); chk("b2b_opa2", s2_opr_a, 64'hA2);
    // bubble
    s1_valid = 0;
    step(); chk("bubble_valid", s2_valid, 0); chk("bubble_pc_hold", s2_pc, 64'h108);
    // load-use stall
    s1_valid = 1;
    instr(64'h200, 2, 1, 0, 0, 5, 1, 64'h1, 64'h0, 5'd0);
    step(); chk("ld_rd", s2_rd, 5); s2_ready = 0;
    instr(64'h204, 5, 1, 1, 1, 6, 1, 64'h1111, 64'h2222, 5'd1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", s1_ready, 0);
      step(); chk("stall_pc_hold", s2_pc, 64'h200);
    end
    s2_rd_wen = 1; s2_rd_addr = 5; s2_rd_wdata = 64'hDEAD; s2_ready = 1;
    #1 chk("release_ready", s1_ready, 1);
    step(); chk("fwd_pc", s2_pc, 64'h204); chk("fwd_opa", s2_opr_a, 64'hDEAD);
    chk("fwd_opb", s2_opr_b, 64'h2222); chk("fwd_opc", s2_opr_c, 64'hC0C0);
    s2_rd_wen = 0;
    // hazard holds even when execute retires the producer
    instr(64'h208, 0, 0, 6, 1, 7, 1, 64'h3, 64'h4, 5'd1);
    #1 chk("haz_w_ready", s1_ready, 0);
    step(); chk("retire_empty", s2_valid, 0);
    #1 chk("empty_ready", s1_ready, 1);
    step(); chk("cap_208", s2_pc, 64'h208);
    // writeback while held clears the pending write
    s2_ready = 0; s1_valid = 0; s2_rd_wen = 1; s2_rd_addr = 7; s2_rd_wdata = 64'h9;
    step(); s2_rd_wen = 0; s1_valid = 1; s2_ready = 1;
    instr(64'h20C, 7, 1, 0, 0, 0, 0, 64'h5, 64'h0, 5'd2);
    #1 chk("pend_cleared_ready", s1_ready, 1);
    step();
    // x0: no stall, no forward
    instr(64'h300, 1, 1, 0, 0, 0, 1, 64'h1, 64'h0, 5'd1);
    step(); chk("x0_held_rd", s2_rd, 0);
    instr(64'h304, 0, 1, 0, 0, 8, 1, 64'h77, 64'h0, 5'd1);
    s2_rd_wen = 1; s2_rd_addr = 0; s2_rd_wdata = 64'h55;
    #1 chk("x0_ready", s1_ready, 1);
    step(); chk("x0_opa", s2_opr_a, 64'h77);
    s2_rd_wen = 0; s2_ready = 0;
    // flush
    instr(64'h400, 1, 1, 0, 0, 9, 1, 64'h1, 64'h0, 5'd5);
    s2_cf_valid = 1;
    #1 chk("cf1_ready", s1_ready, 0);
    step(); chk("cf1_pc", s2_pc, 64'h304); chk("cf1_valid", s2_valid, 1);
    s2_cf_ack = 1;
    #1 chk("cf2_ready", s1_ready, 0);
    step(); chk("cf2_valid", s2_valid, 0); chk("cf2_pc", s2_pc, 64'h304);
    s2_cf_valid = 0; s2_cf_ack = 0;
    #1 chk("cf3_ready", s1_ready, 1);
    step(); chk("cf3_pc", s2_pc, 64'h400); chk("cf3_valid", s2_valid, 1);
    // async reset mid-stall
    instr(64'h404, 9, 1, 0, 0, 10, 1, 64'h1, 64'h0, 5'd1);
    #1 chk("rst_stall_ready", s1_ready, 0);
    #1 g_resetn = 0;
    #1 chk("rst_async_valid", s2_valid, 0); chk("rst_async_alu", s2_alu_op, 0);
    chk("rst_async_pc", s2_pc, 0);
    step(); g_resetn = 1;
    #1 chk("rst_release_ready", s1_ready, 1);
    step(); chk("rst_cap_pc", s2_pc, 64'h404); chk("rst_cap_valid", s2_valid, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
